// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// MDU sequencer states and the shadow-stage field width.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // Number of single-bit flags per shadow stage: we, load, mdu, rs1_used, rs2_used
    localparam int unsigned SHADOW_FLAGS = 5;

    // Shadow payload width (rd, rs1, rs2 plus flags), excluding the valid bit
    function automatic int unsigned shadow_w(input int unsigned aw);
        return 3 * aw + SHADOW_FLAGS;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_shadow_stage.sv
// One shadow pipeline stage: valid bit plus payload, with load, hold and
// synchronous bubble insertion (clear of the valid bit).
module pipe_shadow_stage
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned W = shadow_w(5)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_en,
    input  logic         clr,
    input  logic         valid_d,
    input  logic [W-1:0] data_d,
    output logic         valid_q,
    output logic [W-1:0] data_q
);

    // Stage register: clear wins over load; neither means hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr) begin
            valid_q <= 1'b0;
        end else if (load_en) begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes, MDU
// occupancy stalls with watchdog, and EX operand forwarding selects, all
// derived from an internal EX/MEM/WB shadow of decode-stage fields.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MDU_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_reg_we_i,
    input  logic              id_is_load_i,
    input  logic              id_is_mdu_i,
    input  logic              ex_br_taken_i,
    input  logic              mdu_done_i,
    output logic              stall_pc_o,
    output logic              stall_if_id_o,
    output logic              flush_if_id_o,
    output logic              bubble_id_ex_o,
    output logic              hold_id_ex_o,
    output logic              mdu_start_o,
    output logic              mdu_err_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              we;
        logic              load;
        logic              mdu;
        logic              rs1_used;
        logic              rs2_used;
    } shadow_t;

    localparam int unsigned SW   = $bits(shadow_t);
    localparam int unsigned WD_W = $clog2(MDU_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

    shadow_t         id_f, ex_q, mem_q, wb_q;
    logic [SW-1:0]   ex_raw, mem_raw, wb_raw;
    logic            ex_v, mem_v, wb_v;

    mdu_state_e      state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            mdu_launch, wd_expired, mdu_stall;
    logic            load_use, br_flush;

    assign id_f = '{rd: id_rd_i, rs1: id_rs1_i, rs2: id_rs2_i,
                    we: id_reg_we_i, load: id_is_load_i, mdu: id_is_mdu_i,
                    rs1_used: id_rs1_used_i, rs2_used: id_rs2_used_i};

    // EX holds during an MDU stall; MEM receives a bubble for every held cycle
    pipe_shadow_stage #(.W(SW)) u_ex (
        .clk(clk), .rst_n(rst_n), .load_en(~hold_id_ex_o), .clr(1'b0),
        .valid_d(id_valid_i & ~bubble_id_ex_o), .data_d(id_f),
        .valid_q(ex_v), .data_q(ex_raw)
    );

    pipe_shadow_stage #(.W(SW)) u_mem (
        .clk(clk), .rst_n(rst_n), .load_en(1'b1), .clr(hold_id_ex_o),
        .valid_d(ex_v), .data_d(ex_raw),
        .valid_q(mem_v), .data_q(mem_raw)
    );

    pipe_shadow_stage #(.W(SW)) u_wb (
        .clk(clk), .rst_n(rst_n), .load_en(1'b1), .clr(1'b0),
        .valid_d(mem_v), .data_d(mem_raw),
        .valid_q(wb_v), .data_q(wb_raw)
    );

    assign ex_q  = shadow_t'(ex_raw);
    assign mem_q = shadow_t'(mem_raw);
    assign wb_q  = shadow_t'(wb_raw);

    // Later stages only need rd/we for forwarding
    logic unused_fields;
    assign unused_fields = ^{mem_q.rs1, mem_q.rs2, mem_q.load, mem_q.mdu,
                             mem_q.rs1_used, mem_q.rs2_used,
                             wb_q.rs1, wb_q.rs2, wb_q.load, wb_q.mdu,
                             wb_q.rs1_used, wb_q.rs2_used};

    assign mdu_launch = ex_v & ex_q.mdu;
    assign wd_expired = (wd_q == WD_LAST);

    // MDU sequencer state, watchdog and sticky error register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // MDU next-state, launch pulse and stall request
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        err_d       = err_q;
        mdu_start_o = 1'b0;
        mdu_stall   = 1'b0;
        unique case (state_q)
            MDU_IDLE: begin
                if (mdu_launch) begin
                    mdu_start_o = 1'b1;
                    if (!mdu_done_i) begin
                        state_d   = MDU_BUSY;
                        wd_d      = '0;
                        mdu_stall = 1'b1;
                    end
                end
            end
            MDU_BUSY: begin
                wd_d = wd_q + 1'b1;
                if (mdu_done_i || wd_expired) begin
                    state_d = MDU_IDLE;
                    if (!mdu_done_i) err_d = 1'b1;
                end else begin
                    mdu_stall = 1'b1;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    assign mdu_err_o = err_q;

    assign load_use = id_valid_i & ex_v & ex_q.load & ex_q.we & (ex_q.rd != '0) &
                      ((id_rs1_used_i & (id_rs1_i == ex_q.rd)) |
                       (id_rs2_used_i & (id_rs2_i == ex_q.rd)));

    // Gated by reset so every output reads 0 while rst_n is low
    assign br_flush = ex_br_taken_i & rst_n;

    // Pipeline control priority: MDU occupancy, then branch flush, then load-use
    always_comb begin
        stall_pc_o     = 1'b0;
        stall_if_id_o  = 1'b0;
        flush_if_id_o  = 1'b0;
        bubble_id_ex_o = 1'b0;
        hold_id_ex_o   = 1'b0;
        if (mdu_stall) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            hold_id_ex_o  = 1'b1;
        end else if (br_flush) begin
            flush_if_id_o  = 1'b1;
            bubble_id_ex_o = 1'b1;
        end else if (load_use) begin
            stall_pc_o     = 1'b1;
            stall_if_id_o  = 1'b1;
            bubble_id_ex_o = 1'b1;
        end
    end

    function automatic fwd_sel_e fwd_pick(input logic used, input logic [REG_AW-1:0] rs,
                                          input logic mv, input shadow_t m,
                                          input logic wv, input shadow_t w);
        if (!used || rs == '0)            return FWD_RF;
        if (mv && m.we && (m.rd == rs))   return FWD_EXMEM;
        if (wv && w.we && (w.rd == rs))   return FWD_MEMWB;
        return FWD_RF;
    endfunction

    assign fwd_a_o = fwd_pick(ex_q.rs1_used, ex_q.rs1, mem_v, mem_q, wb_v, wb_q);
    assign fwd_b_o = fwd_pick(ex_q.rs2_used, ex_q.rs2, mem_v, mem_q, wb_v, wb_q);

endmodule
